lifo_stack_param: RTL and testbench

//   Parametrised synchronous LIFO (stack) with occupancy count, almost-full flag,

---
 rtl/lifo_stack_param.sv | 106 ++++++++++
 tb/tb_lifo_stack_param.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/lifo_stack_param.sv
// Parametrised synchronous LIFO with occupancy count, almost-full flag,
// simultaneous push/pop (replace-top / pass-through), flush and sticky
// overflow/underflow flags. Status flags decode the registered count only.
module lifo_stack_param #(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 16,
  parameter  int AF_THRESH = DEPTH - 2,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             flush,
  input  logic             clear_err,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    nxt_idx;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(AF_THRESH));

  // Index of the current top entry and of the first free slot; only used
  // when the corresponding empty/full guard allows, so truncation is safe.
  assign top_idx = AW'(count - CW'(1));
  assign nxt_idx = AW'(count);

  // Memory write select: push into free slot, or overwrite top on replace.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = nxt_idx;
    if (!reset && !flush && push) begin
      if (pop && !empty) begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else if (!pop && !full) begin
        wr_en  = 1'b1;
      end
    end
  end

  // Storage array; no reset so it maps onto plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= din;
  end

  // Occupancy, popped-data register and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      // Clear first so an error raised below in the same cycle wins.
      if (clear_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (flush) begin
        count <= '0;
      end else begin
        unique case ({push, pop})
          2'b10: begin
            if (full) overflow <= 1'b1;
            else      count    <= count + CW'(1);
          end
          2'b01: begin
            if (empty) begin
              underflow <= 1'b1;
            end else begin
              dout       <= mem[top_idx];
              dout_valid <= 1'b1;
              count      <= count - CW'(1);
            end
          end
          2'b11: begin
            // Replace-top returns the old top; on empty, data passes through.
            dout       <= empty ? din : mem[top_idx];
            dout_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lifo_stack_param.sv
// Scoreboard bench for lifo_stack_param: a queue-based stack model predicts
// state after every cycle; expected pop data is queued and a separate
// monitor consumes it whenever the DUT raises dout_valid.
module tb_lifo_stack_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AFT   = 14;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset, push, pop, flush, clear_err;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dout_valid, full, empty, almost_full, overflow, underflow;
  logic [CW-1:0]    count;

  lifo_stack_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AFT)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
    .flush(flush), .clear_err(clear_err), .dout(dout),
    .dout_valid(dout_valid), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [WIDTH-1:0] stk[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_vld, m_ovf, m_udf;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every dout_valid pulse must match the oldest expected pop.
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_unexpected: dout_valid with dout=%0h, nothing expected", dout);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        chk("sb_dout", int'(dout), int'(e));
      end
    end
  end

  task automatic model(input bit pu, po, input logic [WIDTH-1:0] d,
                       input bit fl, ce, rs);
    m_vld = 1'b0;
    if (rs) begin
      stk.delete(); m_dout = '0; m_ovf = 0; m_udf = 0;
      return;
    end
    if (ce) begin m_ovf = 0; m_udf = 0; end
    if (fl) begin stk.delete(); return; end
    if (pu && !po) begin
      if (stk.size() == DEPTH) m_ovf = 1;
      else stk.push_back(d);
    end else if (po && !pu) begin
      if (stk.size() == 0) m_udf = 1;
      else begin m_dout = stk.pop_back(); m_vld = 1; end
    end else if (pu && po) begin
      if (stk.size() == 0) m_dout = d;
      else begin m_dout = stk.pop_back(); stk.push_back(d); end
      m_vld = 1;
    end
    if (m_vld) exp_q.push_back(m_dout);
  endtask

  // One clock of stimulus, then compare all visible state to the model.
  task automatic step(input bit pu, po, input logic [WIDTH-1:0] d,
                      input bit fl = 0, ce = 0, rs = 0);
    push = pu; pop = po; din = d; flush = fl; clear_err = ce; reset = rs;
    @(posedge clk); #1;
    model(pu, po, d, fl, ce, rs);
    chk("count",       int'(count),       stk.size());
    chk("full",        int'(full),        int'(stk.size() == DEPTH));
    chk("empty",       int'(empty),       int'(stk.size() == 0));
    chk("almost_full", int'(almost_full), int'(stk.size() >= AFT));
    chk("overflow",    int'(overflow),    int'(m_ovf));
    chk("underflow",   int'(underflow),   int'(m_udf));
    chk("dout",        int'(dout),        int'(m_dout));
    chk("dout_valid",  int'(dout_valid),  int'(m_vld));
  endtask

  initial begin
    reset = 1; push = 0; pop = 0; din = '0; flush = 0; clear_err = 0;
    m_dout = '0; m_vld = 0; m_ovf = 0; m_udf = 0;

    // Reset state
    step(0, 0, 8'h00, 0, 0, 1);
    step(0, 0, 8'h00);

    // 1: fill to full, then an overflowing push
    for (int i = 1; i <= DEPTH; i++) step(1, 0, 8'(i));
    chk("t1_full", int'(full), 1);
    step(1, 0, 8'hAA);
    chk("t1_ovf", int'(overflow), 1);

    // 2: drain everything, then underflow (dout keeps 0x01)
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    chk("t2_udf_dout", int'(dout), 8'h01);
    chk("t2_udf", int'(underflow), 1);

    // 3: replace-top on [0x11,0x22]
    step(0, 0, 8'h00, 0, 1);
    step(1, 0, 8'h11); step(1, 0, 8'h22);
    step(1, 1, 8'h33);
    chk("t3_dout", int'(dout), 8'h22);
    step(0, 1, 8'h00);
    chk("t3_pop", int'(dout), 8'h33);
    step(0, 1, 8'h00);

    // 4: pass-through on empty, replace on full
    step(1, 1, 8'h5A);
    chk("t4_pass", int'(dout), 8'h5A);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'($urandom));
    step(1, 1, 8'hC3);
    chk("t4_full_ovf", int'(overflow), 0);
    chk("t4_full_cnt", int'(count), DEPTH);

    // 5: flush with push, then clear_err racing an underflow
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h40 + i));
    step(1, 0, 8'hEE, 1);
    chk("t5_flush", int'(empty), 1);
    step(0, 1, 8'h00, 0, 1);
    chk("t5_set_wins", int'(underflow), 1);

    // 6: reset mid-stream with pop active
    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 7; i++) step(1, 0, 8'(8'h60 + i));
    step(0, 1, 8'h00, 0, 0, 1);
    chk("t6_rst_cnt", int'(count), 0);
    step(1, 0, 8'h77);
    step(0, 1, 8'h00);
    chk("t6_pop", int'(dout), 8'h77);

    // Random traffic, alternating fill-biased and drain-biased phases
    for (int n = 0; n < 1200; n++) begin
      int r, pb;
      bit pu, po, fl, ce, rs;
      pb = ((n / 150) % 2 == 0) ? 65 : 35;
      r  = $urandom_range(0, 99); pu = (r < pb);
      r  = $urandom_range(0, 99); po = (r >= pb);
      fl = ($urandom_range(0, 99) < 2);
      ce = ($urandom_range(0, 99) < 5);
      rs = ($urandom_range(0, 199) < 1);
      step(pu, po, 8'($urandom), fl, ce, rs);
    end

    step(0, 0, 8'h00);
    @(negedge clk); #1;
    chk("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
